// File: rtl/handshake_tx.sv
// handshake_tx: ready/valid transmitter with a 2-entry FIFO.
// Upstream words {in2, in1} are accepted on in_valid/in_ready. They are
// presented downstream on handshake_valid/handshake_ready together with a
// reduction bit: out = (|in1) & (&in1), which is 1 only when in1 is all ones.
// The bit is computed when the word is accepted. All outputs except in_ready
// are derived from registered state. The head entry holds stable under
// back-pressure.
//
// Ports:
//   CLK              in   sole clock, rising edge
//   ASYNCRESETN      in   asynchronous active-low reset
//   in1, in2         in   upstream payload, low/high half (WIDTH bits each)
//   in_valid         in   upstream word present
//   in_ready         out  word can be accepted this cycle
//   out_data         out  head entry {in2, in1}
//   out              out  head entry reduction bit
//   handshake_valid  out  head entry valid downstream
//   handshake_ready  in   downstream takes the head this cycle
//   stall_cnt        out  saturating count of stalled valid cycles
//                         (only when HANDSHAKE_TX_STALL_CNT_EN is defined)
//
// Optional feature macro: HANDSHAKE_TX_STALL_CNT_EN
module handshake_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef HANDSHAKE_TX_STALL_CNT_EN
  output logic [7:0]         stall_cnt,
`endif
  output logic [2*WIDTH-1:0] out_data,
  output logic               out,
  output logic               handshake_valid,
  input  logic               handshake_ready
);

  localparam int unsigned EntryW = 2 * WIDTH + 1;

  // State encodes occupancy directly: 0, 1 or 2 buffered words.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [EntryW-1:0] mem_q [2];
  logic [EntryW-1:0] head;
  logic              push, pop;
  logic              red_bit;

  assign red_bit = (|in1) & (&in1);

  always_comb begin
    // in_ready is gated by reset so nothing is accepted while reset is held.
    in_ready        = (state_q != StFull) & ASYNCRESETN;
    handshake_valid = (state_q != StEmpty);
    push            = in_valid & in_ready;
    pop             = handshake_valid & handshake_ready;
    rd_d            = rd_q ^ pop;
    wr_d            = wr_q ^ push;

    state_d = state_q;
    unique case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (push && !pop)      state_d = StFull;
        else if (pop && !push) state_d = StEmpty;
      end
      StFull:  if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= StEmpty;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Entries are reset so that out_data/out read 0 after reset.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= {in2, in1, red_bit};
    end
  end

  always_comb begin
    head     = mem_q[rd_q];
    out_data = head[EntryW-1:1];
    out      = head[0];
  end

`ifdef HANDSHAKE_TX_STALL_CNT_EN
  logic [7:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (handshake_valid && !handshake_ready && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) stall_q <= 8'd0;
    else              stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_handshake_tx.sv
// Testbench for handshake_tx. Inputs change 1 time unit after the rising
// edge. A monitor samples on the falling edge, records accepted words in a
// scoreboard queue, and checks each popped word and head stability.
module tb_handshake_tx;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rstn;
  logic [W-1:0]   in1, in2;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] out_data;
  logic           out_bit;
  logic           hs_valid;
  logic           hs_ready;
`ifdef HANDSHAKE_TX_STALL_CNT_EN
  logic [7:0]     stall_cnt;
`endif

  handshake_tx #(.WIDTH(W)) dut (
    .CLK             (clk),
    .ASYNCRESETN     (rstn),
    .in1             (in1),
    .in2             (in2),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
`ifdef HANDSHAKE_TX_STALL_CNT_EN
    .stall_cnt       (stall_cnt),
`endif
    .out_data        (out_data),
    .out             (out_bit),
    .handshake_valid (hs_valid),
    .handshake_ready (hs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rx    = 0;
  logic [2*W:0] exp_q [$];

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Monitor: scoreboard and hold-stability checks.
  logic         hold_q = 1'b0;
  logic [2*W:0] held_q = '0;

  always @(negedge clk) begin
    if (rstn) begin
      if (hold_q) begin
        check("hold_valid", 32'(hs_valid), 32'd1);
        check("hold_data", 32'({out_data, out_bit}), 32'(held_q));
      end
      if (hs_valid && hs_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'({out_data, out_bit}), 32'h1ff);
        end else begin
          check("pop_word", 32'({out_data, out_bit}), 32'(exp_q.pop_front()));
        end
        n_rx++;
      end
      if (in_valid && in_ready) exp_q.push_back({in2, in1, &in1});
      hold_q <= hs_valid & ~hs_ready;
      held_q <= {out_data, out_bit};
    end else begin
      hold_q <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    logic acc;
    rstn     = 1'b0;
    in1      = '0;
    in2      = '0;
    in_valid = 1'b0;
    hs_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(hs_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_out", 32'(out_bit), 32'd0);
    rstn = 1'b1;
    step();
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_valid", 32'(hs_valid), 32'd0);

    // Single word
    hs_ready = 1'b1;
    in1 = 4'hF; in2 = 4'hA; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_valid", 32'(hs_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hAF);
    check("single_out", 32'(out_bit), 32'd1);
    step();
    check("single_empty", 32'(hs_valid), 32'd0);

    // Back-pressure
    hs_ready = 1'b0;
    in1 = 4'h3; in2 = 4'h1; in_valid = 1'b1;
    step();
    in1 = 4'hF; in2 = 4'h2;
    step();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    in1 = 4'h5; in2 = 4'h5;
    step();
    step();
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_head", 32'(out_data), 32'h13);
    check("bp_head_out", 32'(out_bit), 32'd0);
    in_valid = 1'b0;
    hs_ready = 1'b1;
    step();
    check("bp_second", 32'(out_data), 32'h2F);
    check("bp_second_out", 32'(out_bit), 32'd1);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    check("bp_drained", 32'(hs_valid), 32'd0);

    // Simultaneous push and pop while holding one word
    hs_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in1 = W'(i); in2 = ~W'(i);
      step();
      check("pp_valid", 32'(hs_valid), 32'd1);
      check("pp_in_ready", 32'(in_ready), 32'd1);
      check("pp_in1", 32'(out_data[W-1:0]), 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("pp_empty", 32'(hs_valid), 32'd0);

    // Random traffic with random back-pressure
    n_rx = 0;
    sent = 0;
    in_valid = 1'b1;
    in1 = ($urandom_range(0, 3) == 0) ? 4'hF : W'($urandom);
    in2 = W'($urandom);
    for (int c = 0; c < 5000 && sent < 200; c++) begin
      hs_ready = 1'($urandom);
      acc = in_ready;
      step();
      if (acc) begin
        sent++;
        in1 = ($urandom_range(0, 3) == 0) ? 4'hF : W'($urandom);
        in2 = W'($urandom);
      end
    end
    in_valid = 1'b0;
    hs_ready = 1'b1;
    for (int k = 0; k < 50 && (exp_q.size() != 0 || hs_valid); k++) step();
    check("rand_sent", 32'(sent), 32'd200);
    check("rand_received", 32'(n_rx), 32'd200);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while full
    hs_ready = 1'b0;
    in_valid = 1'b1;
    in1 = 4'h7; in2 = 4'h9;
    step();
    in1 = 4'hF; in2 = 4'h4;
    step();
    in_valid = 1'b0;
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(hs_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_data", 32'(out_data), 32'd0);
    check("post_rst_out", 32'(out_bit), 32'd0);
    hs_ready = 1'b1;
    n_rx = 0;
    for (int k = 0; k < 4; k++) step();
    check("no_stale_word", 32'(n_rx), 32'd0);

`ifdef HANDSHAKE_TX_STALL_CNT_EN
    check("stall_reset", 32'(stall_cnt), 32'd0);
    hs_ready = 1'b0;
    in1 = 4'h1; in2 = 4'h2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 300; k++) step();
    check("stall_sat", 32'(stall_cnt), 32'd255);
    hs_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();
    in_valid = 1'b0;
    step();
    step();
    check("stall_hold", 32'(stall_cnt), 32'd255);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("stall_clear", 32'(stall_cnt), 32'd0);
    rstn = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
